// File: rtl/ervp_asynch_fifo_write_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// A grant covers one whole FIFO word, so partial beats of different requesters never interleave.
module ervp_asynch_fifo_write_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int BW_PARTIAL_WRITE = 32,
  parameter int BW_NUM_DATA      = 32
) (
  input  logic                                  clk,
  input  logic                                  rstnn,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*BW_PARTIAL_WRITE-1:0]   req_data,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic                                  fifo_wready,
  input  logic                                  fifo_wstartindex,
  input  logic                                  fifo_wlastindex,
  input  logic [BW_NUM_DATA-1:0]                fifo_wnum,
  output logic                                  fifo_wrequest,
  output logic [BW_PARTIAL_WRITE-1:0]           fifo_wdata,
  output logic [NUM_REQ-1:0]                    grant,
  output logic                                  busy,
  output logic                                  misalign
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IW-1:0]      last_q;
  logic               misalign_q;

  logic [IW-1:0]      winner_d;
  logic [IW-1:0]      cand;
  logic               found;
  logic               wnum_pos;
  logic               beat_xfer;

  // wnum is a signed free-word count; only strictly positive values allow a new word.
  assign wnum_pos = ~fifo_wnum[BW_NUM_DATA-1] & (|fifo_wnum);

  // Scan from last+1 so the previous owner has the lowest priority.
  always_comb begin
    winner_d = last_q;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        winner_d = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready     = '0;
    fifo_wrequest = 1'b0;
    fifo_wdata    = '0;
    if (state_q == BURST) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q[i]) begin
          fifo_wrequest = req_valid[i];
          fifo_wdata    = req_data[i*BW_PARTIAL_WRITE +: BW_PARTIAL_WRITE];
          req_ready[i]  = fifo_wready;
        end
      end
    end
  end

  assign beat_xfer = fifo_wrequest & fifo_wready;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IW'(NUM_REQ - 1);
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_wstartindex) begin
            misalign_q <= 1'b1;
          end else if ((|req_valid) && wnum_pos) begin
            grant_q <= NUM_REQ'(1) << winner_d;
            last_q  <= winner_d;
            state_q <= BURST;
          end
        end
        BURST: begin
          // The word ends only on an accepted last beat; stalls and valid gaps keep the grant.
          if (beat_xfer && fifo_wlastindex) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q == BURST);
  assign misalign = misalign_q;

endmodule

// File: tb/tb_ervp_asynch_fifo_write_arbiter.sv
// Bench for ervp_asynch_fifo_write_arbiter: a word-level FIFO model and per-requester word queues
// drive random traffic; a round-robin owner model predicts every output each cycle.
module tb_ervp_asynch_fifo_write_arbiter;
  localparam int N = 4, BW = 8, DEPTH = 4, BEATS = 4;

  logic            clk = 1'b0;
  logic            rstnn;
  logic [N-1:0]    req_valid;
  logic [N*BW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_wready, fifo_wstartindex, fifo_wlastindex;
  logic [31:0]     fifo_wnum;
  logic            fifo_wrequest;
  logic [BW-1:0]   fifo_wdata;
  logic [N-1:0]    grant;
  logic            busy, misalign;

  always #5 clk = ~clk;

  ervp_asynch_fifo_write_arbiter #(.NUM_REQ(N), .BW_PARTIAL_WRITE(BW), .BW_NUM_DATA(32)) dut (
    .clk(clk), .rstnn(rstnn), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wready(fifo_wready), .fifo_wstartindex(fifo_wstartindex), .fifo_wlastindex(fifo_wlastindex),
    .fifo_wnum(fifo_wnum), .fifo_wrequest(fifo_wrequest), .fifo_wdata(fifo_wdata),
    .grant(grant), .busy(busy), .misalign(misalign));

  int n_chk = 0, n_pass = 0;

  logic [BW-1:0] rq [N][$];
  logic [31:0]   ew [N][$];
  logic [31:0]   fifo_mem [$];
  int            grant_log [$];

  int          m_owner, m_last;
  logic        m_mis;
  int          fidx;
  logic [31:0] partial, last_word;
  logic [N-1:0] en;
  int          hold [N];
  int          gap_pct, stall_pct, rd_pct;
  logic        force_nostart, wnum_ovr_en;
  int          wnum_ovr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int pending();
    int s = 0;
    for (int r = 0; r < N; r++) s += ew[r].size();
    return s;
  endfunction

  task automatic push_word(input int r, input logic [31:0] w);
    for (int b = 0; b < BEATS; b++) rq[r].push_back(w[b*BW +: BW]);
    ew[r].push_back(w);
  endtask

  task automatic cycle();
    int free, wn, nxt, c;
    logic [N-1:0]  v, exp_rdy;
    logic          exp_wreq;
    logic [BW-1:0] exp_wdata;
    logic [31:0]   expw;
    for (int r = 0; r < N; r++) begin
      v[r] = en[r] && (rq[r].size() > 0) && (hold[r] == 0) && ($urandom_range(0, 99) >= gap_pct);
      req_data[r*BW +: BW] = (rq[r].size() > 0) ? rq[r][0] : '0;
    end
    req_valid        = v;
    free             = DEPTH - fifo_mem.size() - ((fidx != 0) ? 1 : 0);
    fifo_wready      = ((fidx != 0) || (free > 0)) && ($urandom_range(0, 99) >= stall_pct);
    fifo_wstartindex = (fidx == 0) && !force_nostart;
    fifo_wlastindex  = (fidx == BEATS - 1);
    wn               = wnum_ovr_en ? wnum_ovr : free;
    fifo_wnum        = 32'(wn);
    #4;
    exp_wreq = 1'b0; exp_wdata = '0; exp_rdy = '0;
    if (m_owner >= 0) begin
      exp_wreq         = v[m_owner];
      exp_wdata        = req_data[m_owner*BW +: BW];
      exp_rdy[m_owner] = fifo_wready;
    end
    chk("grant", 32'(grant), (m_owner >= 0) ? (32'(1) << m_owner) : 32'(0));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("wrequest", 32'(fifo_wrequest), 32'(exp_wreq));
    chk("wdata", 32'(fifo_wdata), 32'(exp_wdata));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("misalign", 32'(misalign), 32'(m_mis));
    // Reference arbitration decision for the coming edge.
    nxt = m_owner;
    if (m_owner < 0) begin
      if (!fifo_wstartindex) m_mis = 1'b1;
      else if (v != '0 && wn > 0) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (nxt < 0 && v[c]) nxt = c;
        end
        m_last = nxt;
        grant_log.push_back(nxt);
      end
    end else if (v[m_owner] && fifo_wready && fifo_wlastindex) nxt = -1;
    // FIFO and requesters react to what the DUT actually drives.
    if (fifo_wrequest && fifo_wready) begin
      partial[fidx*BW +: BW] = fifo_wdata;
      fidx++;
      if (fidx == BEATS) begin
        fidx = 0;
        fifo_mem.push_back(partial);
        last_word = partial;
        expw = 'x;
        if (m_owner >= 0 && ew[m_owner].size() > 0) expw = ew[m_owner].pop_front();
        chk("word", partial, expw);
      end
    end
    for (int r = 0; r < N; r++) if (v[r] && req_ready[r]) void'(rq[r].pop_front());
    if (fifo_mem.size() > 0 && $urandom_range(0, 99) < rd_pct) void'(fifo_mem.pop_front());
    for (int r = 0; r < N; r++) if (hold[r] > 0) hold[r]--;
    m_owner = nxt;
    @(posedge clk); #1;
  endtask

  task automatic run_words(input string tag, input int bound);
    int n = 0;
    while (pending() > 0 && n < bound) begin cycle(); n++; end
    chk(tag, 32'(pending()), 32'(0));
  endtask

  task automatic do_reset();
    rstnn = 1'b0;
    req_valid = '0; req_data = '0;
    #1;
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_misalign", 32'(misalign), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_wrequest", 32'(fifo_wrequest), 32'(0));
    chk("rst_wdata", 32'(fifo_wdata), 32'(0));
    for (int r = 0; r < N; r++) begin rq[r].delete(); ew[r].delete(); hold[r] = 0; end
    fifo_mem.delete(); grant_log.delete();
    fidx = 0; m_owner = -1; m_last = N - 1; m_mis = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rstnn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic dropped;
    en = '0; gap_pct = 0; stall_pct = 0; rd_pct = 50;
    force_nostart = 1'b0; wnum_ovr_en = 1'b0; wnum_ovr = 0; partial = '0; last_word = '0;
    fifo_wready = 1'b0; fifo_wstartindex = 1'b1; fifo_wlastindex = 1'b0; fifo_wnum = '0;
    do_reset();

    // 1: single requester, single word
    push_word(0, 32'hDDCCBBAA); en = 4'b0001;
    cycle();
    chk("t1_grant", 32'(grant), 32'h1);
    run_words("t1_done", 50);
    cycle();
    chk("t1_word", last_word, 32'hDDCCBBAA);
    chk("t1_idle", 32'(grant), 32'h0);

    // 2: all four contend, two words each, with FIFO stalls
    do_reset();
    for (int r = 0; r < N; r++) begin push_word(r, $urandom()); push_word(r, $urandom()); end
    en = 4'b1111; stall_pct = 20;
    run_words("t2_done", 600);
    chk("t2_nwords", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < grant_log.size() && i < 8; i++) chk("t2_order", 32'(grant_log[i]), 32'(i % N));
    stall_pct = 0;

    // 3: full FIFO blocks the grant
    rd_pct = 100; n = 0;
    while (fifo_mem.size() > 0 && n < 20) begin cycle(); n++; end
    rd_pct = 0;
    for (int w = 0; w < DEPTH; w++) push_word(0, $urandom());
    en = 4'b0011;
    run_words("t3_fill", 100);
    push_word(1, 32'h13579BDF);
    repeat (6) cycle();
    chk("t3_nogrant", 32'(grant), 32'h0);
    wnum_ovr_en = 1'b1; wnum_ovr = -3;
    repeat (3) cycle();
    chk("t3_neg_wnum", 32'(grant), 32'h0);
    wnum_ovr_en = 1'b0;
    void'(fifo_mem.pop_front());
    n = 0;
    while (grant !== 4'b0010 && n < 2) begin cycle(); n++; end
    chk("t3_grant_lat", 32'(grant), 32'h2);
    rd_pct = 50;
    run_words("t3_done", 100);

    // 4: owner pauses mid-word; the other requester waits
    grant_log.delete();
    push_word(2, 32'hA4A3A2A1); push_word(3, 32'hB4B3B2B1);
    en = 4'b1100; dropped = 1'b0; n = 0;
    while (pending() > 0 && n < 200) begin
      if (!dropped && rq[2].size() == 2) begin hold[2] = 5; dropped = 1'b1; end
      cycle(); n++;
      if (dropped && hold[2] > 0) chk("t4_hold_grant", 32'(grant), 32'h4);
    end
    chk("t4_done", 32'(pending()), 32'(0));
    chk("t4_first", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd2);
    chk("t4_second", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'd3);

    // 5: reset in the middle of a word
    push_word(1, 32'h44332211); en = 4'b0010; n = 0;
    while (rq[1].size() > 2 && n < 40) begin cycle(); n++; end
    chk("t5_busy_pre", 32'(busy), 32'h1);
    do_reset();
    push_word(0, 32'h0F0E0D0C); en = 4'b0001;
    run_words("t5_done", 50);
    chk("t5_word", last_word, 32'h0F0E0D0C);
    chk("t5_misalign", 32'(misalign), 32'h0);

    // random traffic with gaps, stalls and reads
    gap_pct = 30; stall_pct = 20; rd_pct = 50; en = 4'b1111;
    for (int w = 0; w < 40; w++) push_word($urandom_range(0, N - 1), $urandom());
    run_words("rand_done", 3000);
    gap_pct = 0; stall_pct = 0;

    // 6: misaligned start index in IDLE
    n = 0;
    while (busy && n < 20) begin cycle(); n++; end
    force_nostart = 1'b1;
    push_word(3, 32'hC4C3C2C1); en = 4'b1000;
    repeat (5) cycle();
    chk("t6_nogrant", 32'(grant), 32'h0);
    chk("t6_misalign", 32'(misalign), 32'h1);
    force_nostart = 1'b0;
    run_words("t6_done", 50);
    cycle();
    chk("t6_sticky", 32'(misalign), 32'h1);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
